// File: rtl/vga_dac_pattern_gen_pkg.sv
// Shared timing defaults, pattern mode encodings and width helper for the VGA DAC front end.
package vga_dac_pattern_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CODE_W_DEF   = 4;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_HGRAD = 2'd1,
    MODE_VGRAD = 2'd2,
    MODE_EXT   = 2'd3
  } mode_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_dac_pattern_gen_timing.sv
// Raster position counters and raw (unregistered) sync/blank/frame_start, line_end, frame_end.
module vga_dac_pattern_gen_timing
  import vga_dac_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic line_end_o,
  output logic frame_end_o,
  output logic hsync_act_o,
  output logic vsync_act_o,
  output logic blank_o,
  output logic frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = cnt_width(H_TOTAL);
  localparam int V_W     = cnt_width(V_TOTAL);

  logic [H_W-1:0] hpos_q, hpos_d;
  logic [V_W-1:0] vpos_q, vpos_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  always_comb begin
    line_end_o  = (hpos_q == H_W'(H_TOTAL - 1));
    frame_end_o = line_end_o && (vpos_q == V_W'(V_TOTAL - 1));
    hpos_d      = line_end_o ? '0 : hpos_q + 1'b1;
    vpos_d      = vpos_q;
    if (line_end_o) vpos_d = frame_end_o ? '0 : vpos_q + 1'b1;
  end

  always_comb begin
    hsync_act_o   = (hpos_q >= H_W'(H_ACTIVE + H_FP)) &&
                    (hpos_q <  H_W'(H_ACTIVE + H_FP + H_SYNC));
    vsync_act_o   = (vpos_q >= V_W'(V_ACTIVE + V_FP)) &&
                    (vpos_q <  V_W'(V_ACTIVE + V_FP + V_SYNC));
    blank_o       = (hpos_q >= H_W'(H_ACTIVE)) || (vpos_q >= V_W'(V_ACTIVE));
    frame_start_o = (hpos_q == '0) && (vpos_q == '0);
  end

endmodule

// File: rtl/vga_dac_pattern_gen.sv
// VGA DAC front end: frame-deferred mode register, bar/gradient step counters, output register stage.
module vga_dac_pattern_gen
  import vga_dac_pattern_gen_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   CODE_W   = CODE_W_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic [CODE_W-1:0] ext_code_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o,
  output logic              frame_start_o,
  output logic [CODE_W-1:0] r_code_o,
  output logic [CODE_W-1:0] g_code_o,
  output logic [CODE_W-1:0] b_code_o
);

  localparam int BAR_LEN   = H_ACTIVE / 8;
  localparam int HSTEP_LEN = H_ACTIVE / (2 ** CODE_W);
  localparam int VSTEP_LEN = V_ACTIVE / (2 ** CODE_W);
  localparam int BAR_CW    = cnt_width(BAR_LEN);
  localparam int HSTEP_CW  = cnt_width(HSTEP_LEN);
  localparam int VSTEP_CW  = cnt_width(VSTEP_LEN);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  logic line_end, frame_end, hsync_act, vsync_act, blank_raw, frame_start_raw;

  vga_dac_pattern_gen_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_end_o    (line_end),
    .frame_end_o   (frame_end),
    .hsync_act_o   (hsync_act),
    .vsync_act_o   (vsync_act),
    .blank_o       (blank_raw),
    .frame_start_o (frame_start_raw)
  );

  mode_e                mode_q, mode_d;
  logic [2:0]           bar_q, bar_d;
  logic [BAR_CW-1:0]    bar_cnt_q, bar_cnt_d;
  logic [CODE_W-1:0]    hstep_q, hstep_d, vstep_q, vstep_d;
  logic [HSTEP_CW-1:0]  hstep_cnt_q, hstep_cnt_d;
  logic [VSTEP_CW-1:0]  vstep_cnt_q, vstep_cnt_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fs_q, fs_d;
  logic [CODE_W-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_BARS;
      bar_q       <= '0;
      bar_cnt_q   <= BAR_CW'(BAR_LEN - 1);
      hstep_q     <= '0;
      hstep_cnt_q <= HSTEP_CW'(HSTEP_LEN - 1);
      vstep_q     <= '0;
      vstep_cnt_q <= VSTEP_CW'(VSTEP_LEN - 1);
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      blank_q     <= 1'b1;
      fs_q        <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      mode_q      <= mode_d;
      bar_q       <= bar_d;
      bar_cnt_q   <= bar_cnt_d;
      hstep_q     <= hstep_d;
      hstep_cnt_q <= hstep_cnt_d;
      vstep_q     <= vstep_d;
      vstep_cnt_q <= vstep_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
      fs_q        <= fs_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  // Step counters hold the value for the current raster position; down-counters pace the steps.
  always_comb begin
    mode_d      = frame_end ? mode_e'(mode_i) : mode_q;
    bar_d       = bar_q;
    bar_cnt_d   = bar_cnt_q - 1'b1;
    hstep_d     = hstep_q;
    hstep_cnt_d = hstep_cnt_q - 1'b1;
    vstep_d     = vstep_q;
    vstep_cnt_d = vstep_cnt_q;
    if (line_end) begin
      bar_d       = '0;
      bar_cnt_d   = BAR_CW'(BAR_LEN - 1);
      hstep_d     = '0;
      hstep_cnt_d = HSTEP_CW'(HSTEP_LEN - 1);
    end else begin
      if (bar_cnt_q == '0) begin
        bar_cnt_d = BAR_CW'(BAR_LEN - 1);
        bar_d     = (bar_q == 3'd7) ? bar_q : bar_q + 1'b1;
      end
      if (hstep_cnt_q == '0) begin
        hstep_cnt_d = HSTEP_CW'(HSTEP_LEN - 1);
        hstep_d     = (hstep_q == CODE_MAX) ? hstep_q : hstep_q + 1'b1;
      end
    end
    if (frame_end) begin
      vstep_d     = '0;
      vstep_cnt_d = VSTEP_CW'(VSTEP_LEN - 1);
    end else if (line_end) begin
      if (vstep_cnt_q == '0) begin
        vstep_cnt_d = VSTEP_CW'(VSTEP_LEN - 1);
        vstep_d     = (vstep_q == CODE_MAX) ? vstep_q : vstep_q + 1'b1;
      end else begin
        vstep_cnt_d = vstep_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    hsync_d = hsync_act ? SYNC_POL : ~SYNC_POL;
    vsync_d = vsync_act ? SYNC_POL : ~SYNC_POL;
    blank_d = blank_raw;
    fs_d    = frame_start_raw;
    unique case (mode_q)
      MODE_BARS: begin
        r_d = {CODE_W{bar_q[2]}};
        g_d = {CODE_W{bar_q[1]}};
        b_d = {CODE_W{bar_q[0]}};
      end
      MODE_HGRAD: begin
        r_d = hstep_q; g_d = hstep_q; b_d = hstep_q;
      end
      MODE_VGRAD: begin
        r_d = vstep_q; g_d = vstep_q; b_d = vstep_q;
      end
      default: begin
        r_d = ext_code_i; g_d = ext_code_i; b_d = ext_code_i;
      end
    endcase
    if (blank_raw) begin
      r_d = '0; g_d = '0; b_d = '0;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_o       = blank_q;
  assign frame_start_o = fs_q;
  assign r_code_o      = r_q;
  assign g_code_o      = g_q;
  assign b_code_o      = b_q;

endmodule
